// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port, 1-cycle-write memory block.
// Buffers up to DEPTH retired stores and drains them in FIFO order whenever no load
// owns the memory port. A load matching a pending store raises ld_hit and forces draining.
// Optional build macro STORE_BUF_FWD_EN: a load whose youngest matching entry is an SD
// is served from the buffer (ld_fwd_valid) instead of stalling.
module store_buffer #(
  parameter int unsigned MEM_BITS  = 20,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [MEM_BITS-1:0]     st_addr,
  input  logic [2:0]              st_mode,
  input  logic [DATA_SIZE-1:0]    st_data,
  input  logic                    ld_valid,
  input  logic [MEM_BITS-1:0]     ld_addr,
  input  logic [2:0]              ld_mode,
  output logic                    ld_hit,
  output logic                    ld_fwd_valid,
  output logic [DATA_SIZE-1:0]    ld_fwd_data,
  output logic                    mem_we,
  output logic [MEM_BITS-1:0]     mem_address,
  output logic [2:0]              mem_mode,
  output logic [DATA_SIZE-1:0]    mem_wdata,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [MEM_BITS-1:0]  addr_q [DEPTH];
  logic [2:0]           mode_q [DEPTH];
  logic [DATA_SIZE-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [PtrW-1:0]      head_q, head_d;
  logic [PtrW-1:0]      tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;

  logic push;
  logic pop;
  logic any_match;
  logic load_owns;

  assign st_ready = (count_q != FullCnt);
  assign push     = st_valid && st_ready;
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // Compare the load address against every pending entry (a same-cycle push is not seen)
  always_comb begin
    any_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr)) begin
        any_match = 1'b1;
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [PtrW-1:0] young_idx;
  logic            young_sd;

  // Memory-read style extension of forwarded doubleword data
  function automatic logic [DATA_SIZE-1:0] load_extend(input logic [2:0]           mode,
                                                       input logic [DATA_SIZE-1:0] d);
    logic sext;
    sext = ~mode[2];
    unique case (mode[1:0])
      2'b00:   load_extend = {{(DATA_SIZE-8){sext & d[7]}}, d[7:0]};
      2'b01:   load_extend = {{(DATA_SIZE-16){sext & d[15]}}, d[15:0]};
      2'b10:   load_extend = {{(DATA_SIZE-32){sext & d[31]}}, d[31:0]};
      default: load_extend = d;
    endcase
  endfunction

  // Walk from head (oldest) to newest so the last match is the youngest store
  always_comb begin
    young_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[head_q + PtrW'(i)] && (addr_q[head_q + PtrW'(i)] == ld_addr)) begin
        young_idx = head_q + PtrW'(i);
      end
    end
  end

  assign young_sd     = (mode_q[young_idx] == 3'b011);
  assign ld_fwd_valid = ld_valid && any_match && young_sd;
  assign ld_hit       = ld_valid && any_match && !young_sd;
  assign ld_fwd_data  = ld_fwd_valid ? load_extend(ld_mode, data_q[young_idx]) : '0;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
  assign ld_hit       = ld_valid && any_match;
`endif

  // A non-stalled load takes the port; otherwise the head store drains if present
  assign load_owns = ld_valid && !ld_hit;
  assign pop       = !load_owns && (count_q != '0);

  // Memory port mux
  always_comb begin
    mem_we      = pop;
    mem_address = ld_addr;
    mem_mode    = ld_mode;
    mem_wdata   = '0;
    if (pop) begin
      mem_address = addr_q[head_q];
      mem_mode    = mode_q[head_q];
      mem_wdata   = data_q[head_q];
    end
  end

  // Next-state for pointers, occupancy and valid bits
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all pending stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      mode_q[tail_q] <= st_mode;
      data_q[tail_q] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: table of per-cycle vectors plus hand-written reset and
// forwarding sequences. A queue model of pending stores predicts every output each cycle.
module tb_store_buffer;

  localparam int unsigned MB = 20;
  localparam int unsigned DS = 64;
  localparam int unsigned DP = 4;
`ifdef STORE_BUF_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [MB-1:0] st_addr = '0;
  logic [2:0]    st_mode = '0;
  logic [DS-1:0] st_data = '0;
  logic          ld_valid = 1'b0;
  logic [MB-1:0] ld_addr = '0;
  logic [2:0]    ld_mode = '0;
  logic          ld_hit;
  logic          ld_fwd_valid;
  logic [DS-1:0] ld_fwd_data;
  logic          mem_we;
  logic [MB-1:0] mem_address;
  logic [2:0]    mem_mode;
  logic [DS-1:0] mem_wdata;
  logic          empty;
  logic [2:0]    count;

  always #5 clk = ~clk;

  store_buffer #(.MEM_BITS(MB), .DATA_SIZE(DS), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_mode(st_mode),
    .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mode(ld_mode), .ld_hit(ld_hit),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .mem_we(mem_we), .mem_address(mem_address), .mem_mode(mem_mode), .mem_wdata(mem_wdata),
    .empty(empty), .count(count)
  );

  typedef struct {
    logic [MB-1:0] addr;
    logic [2:0]    mode;
    logic [DS-1:0] data;
  } st_t;

  typedef struct {
    logic          sv;
    logic [MB-1:0] sa;
    logic [2:0]    sm;
    logic [DS-1:0] sd;
    logic          lv;
    logic [MB-1:0] la;
    logic [2:0]    lm;
    logic          ewe;
    logic          ehit;
    int            ecnt;
    logic          erdy;
  } vec_t;

  st_t  sb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ext(input logic [2:0] m, input logic [63:0] d);
    case (m)
      3'b000:  return {{56{d[7]}}, d[7:0]};
      3'b001:  return {{48{d[15]}}, d[15:0]};
      3'b010:  return {{32{d[31]}}, d[31:0]};
      3'b100:  return {56'h0, d[7:0]};
      3'b101:  return {48'h0, d[15:0]};
      3'b110:  return {32'h0, d[31:0]};
      default: return d;
    endcase
  endfunction

  // Check every output against the queue model at the falling edge, then advance it
  task automatic cycle();
    logic        match;
    logic [2:0]  ym;
    logic [63:0] yd;
    logic        efwd, ehit, edrain;
    int          n;
    st_t         e;
    @(negedge clk);
    match = 1'b0;
    ym    = '0;
    yd    = '0;
    foreach (sb[i]) begin
      if (sb[i].addr == ld_addr) begin
        match = 1'b1;
        ym    = sb[i].mode;
        yd    = sb[i].data;
      end
    end
    n      = sb.size();
    efwd   = Fwd && ld_valid && match && (ym == 3'b011);
    ehit   = ld_valid && match && !efwd;
    edrain = !(ld_valid && !ehit) && (n != 0);
    chk("st_ready", 64'(st_ready), 64'(n != DP));
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("ld_hit", 64'(ld_hit), 64'(ehit));
    chk("ld_fwd_valid", 64'(ld_fwd_valid), 64'(efwd));
    if (efwd || !Fwd) chk("ld_fwd_data", ld_fwd_data, efwd ? ext(ld_mode, yd) : 64'h0);
    chk("mem_we", 64'(mem_we), 64'(edrain));
    if (edrain) begin
      chk("drain_addr", 64'(mem_address), 64'(sb[0].addr));
      chk("drain_mode", 64'(mem_mode), 64'(sb[0].mode));
      chk("drain_data", mem_wdata, sb[0].data);
    end else begin
      chk("port_addr", 64'(mem_address), 64'(ld_addr));
      chk("port_mode", 64'(mem_mode), 64'(ld_mode));
    end
    @(posedge clk);
    if (edrain) void'(sb.pop_front());
    if (st_valid && (n != DP)) begin
      e.addr = st_addr;
      e.mode = st_mode;
      e.data = st_data;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic addv(input logic sv, input int sa, input logic [2:0] sm, input logic [63:0] sd,
                      input logic lv, input int la, input logic [2:0] lm,
                      input logic ewe, input logic ehit, input int ecnt, input logic erdy);
    vec_t v;
    v.sv = sv; v.sa = MB'(sa); v.sm = sm; v.sd = sd;
    v.lv = lv; v.la = MB'(la); v.lm = lm;
    v.ewe = ewe; v.ehit = ehit; v.ecnt = ecnt; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic idle();
    st_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-to-back SD stores with no loads: one write per cycle, in order
    addv(1, 1, 3'b011, 64'h11, 0, 0, 3'b000, 0, 0, 0, 1);
    addv(1, 2, 3'b011, 64'h22, 0, 0, 3'b000, 1, 0, 1, 1);
    addv(1, 3, 3'b011, 64'h33, 0, 0, 3'b000, 1, 0, 1, 1);
    addv(1, 4, 3'b011, 64'h44, 0, 0, 3'b000, 1, 0, 1, 1);
    addv(0, 0, 3'b000, 64'h0,  0, 0, 3'b000, 1, 0, 1, 1);
    addv(0, 0, 3'b000, 64'h0,  0, 0, 3'b000, 0, 0, 0, 1);
    // Fill while an unrelated load holds the port; a fifth store is refused
    addv(1, 10, 3'b011, 64'hA0, 1, 100, 3'b011, 0, 0, 0, 1);
    addv(1, 11, 3'b011, 64'hA1, 1, 100, 3'b011, 0, 0, 1, 1);
    addv(1, 12, 3'b011, 64'hA2, 1, 100, 3'b011, 0, 0, 2, 1);
    addv(1, 13, 3'b011, 64'hA3, 1, 100, 3'b011, 0, 0, 3, 1);
    addv(1, 14, 3'b011, 64'hA4, 1, 100, 3'b011, 0, 0, 4, 0);
    addv(0, 0, 3'b000, 64'h0, 0, 0, 3'b000, 1, 0, 4, 0);
    addv(0, 0, 3'b000, 64'h0, 0, 0, 3'b000, 1, 0, 3, 1);
    addv(0, 0, 3'b000, 64'h0, 0, 0, 3'b000, 1, 0, 2, 1);
    addv(0, 0, 3'b000, 64'h0, 0, 0, 3'b000, 1, 0, 1, 1);
    addv(0, 0, 3'b000, 64'h0, 0, 0, 3'b000, 0, 0, 0, 1);
    // SW then LW to the same address: stall one cycle, then the load owns the port
    addv(1, 7, 3'b010, 64'hFFFF_FFFF_8000_0000, 0, 0, 3'b000, 0, 0, 0, 1);
    addv(0, 0, 3'b000, 64'h0, 1, 7, 3'b010, 1, 1, 1, 1);
    addv(0, 0, 3'b000, 64'h0, 1, 7, 3'b010, 0, 0, 0, 1);
    // Same-cycle push is not compared; then steady push+pop at count 2 across the wrap
    addv(1, 20, 3'b011, 64'hB0, 1, 20, 3'b011, 0, 0, 0, 1);
    addv(1, 21, 3'b011, 64'hB1, 1, 100, 3'b011, 0, 0, 1, 1);
    addv(1, 22, 3'b011, 64'hB2, 0, 0, 3'b000, 1, 0, 2, 1);
    addv(1, 23, 3'b011, 64'hB3, 0, 0, 3'b000, 1, 0, 2, 1);
    addv(1, 24, 3'b011, 64'hB4, 0, 0, 3'b000, 1, 0, 2, 1);
    addv(0, 0, 3'b000, 64'h0, 0, 0, 3'b000, 1, 0, 2, 1);
    addv(0, 0, 3'b000, 64'h0, 0, 0, 3'b000, 1, 0, 1, 1);
    addv(0, 0, 3'b000, 64'h0, 0, 0, 3'b000, 0, 0, 0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_ld_hit", 64'(ld_hit), 64'd0);
    chk("rst_fwd_valid", 64'(ld_fwd_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      st_valid = vecs[i].sv; st_addr = vecs[i].sa; st_mode = vecs[i].sm; st_data = vecs[i].sd;
      ld_valid = vecs[i].lv; ld_addr = vecs[i].la; ld_mode = vecs[i].lm;
      #2;
      chk($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'(vecs[i].ewe));
      chk($sformatf("v%0d_ld_hit", i), 64'(ld_hit), 64'(vecs[i].ehit));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].ecnt));
      chk($sformatf("v%0d_st_ready", i), 64'(st_ready), 64'(vecs[i].erdy));
      cycle();
    end
    idle();

    // Reset in the middle of a drain with three stores left
    for (int k = 0; k < 4; k++) begin
      st_valid = 1'b1; st_addr = MB'(30 + k); st_mode = 3'b011; st_data = 64'(32'hC0 + k);
      ld_valid = 1'b1; ld_addr = MB'(100); ld_mode = 3'b011;
      cycle();
    end
    idle();
    cycle();
    #2;
    chk("mid_drain_we", 64'(mem_we), 64'd1);
    chk("mid_drain_count", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 64'(mem_we), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_ready", 64'(st_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // Load against a pending SD at addr 9 (forwarded when enabled, stalls otherwise)
    st_valid = 1'b1; st_addr = MB'(9); st_mode = 3'b011; st_data = 64'h80;
    ld_valid = 1'b1; ld_addr = MB'(100); ld_mode = 3'b011;
    cycle();
    st_valid = 1'b0; ld_addr = MB'(9); ld_mode = 3'b000;
    #2;
`ifdef STORE_BUF_FWD_EN
    chk("lb_fwd_valid", 64'(ld_fwd_valid), 64'd1);
    chk("lb_fwd_data", ld_fwd_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ld_hit", 64'(ld_hit), 64'd0);
    chk("lb_mem_we", 64'(mem_we), 64'd0);
    ld_mode = 3'b100;
    #1;
    chk("lbu_fwd_data", ld_fwd_data, 64'h80);
`else
    chk("lb_ld_hit", 64'(ld_hit), 64'd1);
    chk("lb_fwd_valid", 64'(ld_fwd_valid), 64'd0);
    chk("lb_mem_we", 64'(mem_we), 64'd1);
`endif
    cycle();
    // A younger SW to the same address always stalls
    st_valid = 1'b1; st_addr = MB'(9); st_mode = 3'b010; st_data = 64'h1234;
    ld_valid = 1'b1; ld_addr = MB'(100); ld_mode = 3'b011;
    cycle();
    st_valid = 1'b0; ld_addr = MB'(9); ld_mode = 3'b000;
    #2;
    chk("sw_young_ld_hit", 64'(ld_hit), 64'd1);
    chk("sw_young_fwd_valid", 64'(ld_fwd_valid), 64'd0);
    cycle();
    // Stalled load must make progress within DEPTH cycles
    for (int k = 0; k < DP && ld_hit; k++) cycle();
    chk("stall_released", 64'(ld_hit), 64'd0);
    idle();
    for (int k = 0; k < 2 * DP && sb.size() != 0; k++) cycle();
    cycle();
    chk("final_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
